// File: rtl/adc_5g_sync_aligner_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_5g_pkg : sample constants, aligner FSM states and sample helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package adc_5g_pkg;

  localparam int SAMPLE_W = 8;
  localparam int NSAMP    = 8;
  localparam int WORD_W   = SAMPLE_W * NSAMP;
  localparam int NSYNC    = NSAMP / 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    ALIGNED = 2'd2
  } state_e;

  function automatic logic [SAMPLE_W-1:0] sample_of(input logic [WORD_W-1:0] w, input int k);
    return w[k*SAMPLE_W +: SAMPLE_W];
  endfunction

  function automatic logic [1:0] lowest_set4(input logic [NSYNC-1:0] b);
    if (b[0]) return 2'd0;
    if (b[1]) return 2'd1;
    if (b[2]) return 2'd2;
    if (b[3]) return 2'd3;
    return 2'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_5g_sync_aligner_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_5g_sync_aligner_if : FIFO-side sample stream in, re-framed stream and status out
// Rev 1.0
// ----------------------------------------------------------------------------
interface adc_5g_sync_aligner_if #(
  parameter int PERIOD_W  = 24,
  parameter int OVR_CNT_W = 16
);
  import adc_5g_pkg::*;

  logic [WORD_W-1:0]    user_data;
  logic [NSYNC-1:0]     user_sync;
  logic [1:0]           user_outofrange;
  logic                 user_data_valid;
  logic                 arm;
  logic                 ovr_clr;

  logic [WORD_W-1:0]    out_data;
  logic                 out_valid;
  logic                 out_sync;
  logic [1:0]           phase;
  logic                 aligned;
  logic [PERIOD_W-1:0]  sync_period;
  logic                 period_stable;
  logic [OVR_CNT_W-1:0] ovr_count;

  modport master (
    output user_data, user_sync, user_outofrange, user_data_valid, arm, ovr_clr,
    input  out_data, out_valid, out_sync, phase, aligned, sync_period, period_stable, ovr_count
  );

  modport slave (
    input  user_data, user_sync, user_outofrange, user_data_valid, arm, ovr_clr,
    output out_data, out_valid, out_sync, phase, aligned, sync_period, period_stable, ovr_count
  );

endinterface
`default_nettype wire

// File: rtl/adc_5g_sync_aligner_frame_rotator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_5g_frame_rotator : builds an output frame starting at sample 2p of hist
// Rev 1.0
// ----------------------------------------------------------------------------
module adc_5g_frame_rotator
  import adc_5g_pkg::*;
(
  input  logic [WORD_W-1:0] hist_i,
  input  logic [WORD_W-1:0] cur_i,
  input  logic [1:0]        phase_i,
  output logic [WORD_W-1:0] frame_o
);

  always_comb begin
    frame_o = '0;
    for (int k = 0; k < NSAMP; k++) begin
      if (2*int'(phase_i) + k < NSAMP) begin
        frame_o[k*SAMPLE_W +: SAMPLE_W] = sample_of(hist_i, 2*int'(phase_i) + k);
      end else begin
        frame_o[k*SAMPLE_W +: SAMPLE_W] = sample_of(cur_i, 2*int'(phase_i) + k - NSAMP);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_5g_sync_aligner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_5g_sync_aligner : sync phase search, stream re-framing, period/overrange status
// Rev 1.0
// ----------------------------------------------------------------------------
module adc_5g_sync_aligner
  import adc_5g_pkg::*;
#(
  parameter int PERIOD_W  = 24,
  parameter int OVR_CNT_W = 16
) (
  input  logic                        ctrl_clk_in,
  input  logic                        ctrl_reset,
  adc_5g_sync_aligner_if.slave        bus
);

  localparam logic [PERIOD_W-1:0]  CNT_MAX = {PERIOD_W{1'b1}};
  localparam logic [OVR_CNT_W-1:0] OVR_MAX = {OVR_CNT_W{1'b1}};

  state_e               state_q, state_d;
  logic [1:0]           phase_q, phase_d;
  logic [WORD_W-1:0]    hist_q;
  logic [NSYNC-1:0]     hist_sync_q;
  logic                 hist_vld_q;
  logic [WORD_W-1:0]    out_data_q;
  logic                 out_valid_q;
  logic                 out_sync_q;
  logic                 prev_nz_q;
  logic                 have_edge_q;
  logic [PERIOD_W-1:0]  word_cnt_q;
  logic [PERIOD_W-1:0]  sync_period_q;
  logic                 period_stable_q;
  logic [OVR_CNT_W-1:0] ovr_count_q;

  logic                 vin;
  logic                 sync_any;
  logic                 sync_edge;
  logic                 frame_en;
  logic [WORD_W-1:0]    frame;

  // user_data_valid is the FIFO empty flag, so a word is present when it is low
  assign vin       = !bus.user_data_valid;
  assign sync_any  = |bus.user_sync;
  assign sync_edge = vin && sync_any && !prev_nz_q;
  assign frame_en  = vin && hist_vld_q;

  adc_5g_frame_rotator u_rotator (
    .hist_i  (hist_q),
    .cur_i   (bus.user_data),
    .phase_i (phase_q),
    .frame_o (frame)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        phase_d = 2'd0;
        if (bus.arm) state_d = ARMED;
      end
      ARMED: begin
        if (bus.arm) begin
          state_d = ARMED;
        end else if (vin && sync_any) begin
          phase_d = lowest_set4(bus.user_sync);
          state_d = ALIGNED;
        end
      end
      ALIGNED: begin
        if (bus.arm) state_d = ARMED;
      end
      default: begin
        state_d = IDLE;
        phase_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge ctrl_clk_in) begin
    if (ctrl_reset) begin
      state_q         <= IDLE;
      phase_q         <= '0;
      hist_q          <= '0;
      hist_sync_q     <= '0;
      hist_vld_q      <= 1'b0;
      out_data_q      <= '0;
      out_valid_q     <= 1'b0;
      out_sync_q      <= 1'b0;
      prev_nz_q       <= 1'b0;
      have_edge_q     <= 1'b0;
      word_cnt_q      <= '0;
      sync_period_q   <= '0;
      period_stable_q <= 1'b0;
      ovr_count_q     <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      out_valid_q <= frame_en;
      // Frame start is hist sample 2p, covered by hist sync bit p
      out_sync_q  <= frame_en && (state_q == ALIGNED) && hist_sync_q[phase_q];
      if (frame_en) out_data_q <= frame;

      if (vin) begin
        hist_q      <= bus.user_data;
        hist_sync_q <= bus.user_sync;
        hist_vld_q  <= 1'b1;
        prev_nz_q   <= sync_any;
        if (sync_edge) begin
          word_cnt_q <= {{(PERIOD_W-1){1'b0}}, 1'b1};
        end else if (word_cnt_q != CNT_MAX) begin
          word_cnt_q <= word_cnt_q + 1'b1;
        end
      end

      // The first edge after reset or arm only starts the word count
      if (sync_edge) begin
        have_edge_q     <= 1'b1;
        period_stable_q <= 1'b0;
        if (have_edge_q && !bus.arm) begin
          sync_period_q   <= word_cnt_q;
          period_stable_q <= (word_cnt_q == sync_period_q) && (word_cnt_q != '0) &&
                             (word_cnt_q != CNT_MAX);
        end
      end
      if (bus.arm) begin
        have_edge_q     <= 1'b0;
        period_stable_q <= 1'b0;
      end

      if (bus.ovr_clr) begin
        ovr_count_q <= '0;
      end else if (vin && (|bus.user_outofrange) && (ovr_count_q != OVR_MAX)) begin
        ovr_count_q <= ovr_count_q + 1'b1;
      end
    end
  end

  assign bus.out_data      = out_data_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_sync      = out_sync_q;
  assign bus.phase         = phase_q;
  assign bus.aligned       = (state_q == ALIGNED);
  assign bus.sync_period   = sync_period_q;
  assign bus.period_stable = period_stable_q;
  assign bus.ovr_count     = ovr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_5g_sync_aligner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_adc_5g_sync_aligner : directed self-checking bench for adc_5g_sync_aligner
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_adc_5g_sync_aligner;

  logic       clk = 1'b0;
  logic       rst;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] base;
  logic [7:0] bx;

  always #5 clk = ~clk;

  adc_5g_sync_aligner_if #(.PERIOD_W(24), .OVR_CNT_W(16)) bus ();

  adc_5g_sync_aligner #(.PERIOD_W(24), .OVR_CNT_W(16)) dut (
    .ctrl_clk_in (clk),
    .ctrl_reset  (rst),
    .bus         (bus)
  );

  // Word whose sample k is b+k
  function automatic logic [63:0] mkword(input logic [7:0] b);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = b + 8'(k);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.user_data_valid = 1'b1;
    bus.user_sync       = 4'b0000;
    bus.user_outofrange = 2'b00;
    bus.arm             = 1'b0;
    bus.ovr_clr         = 1'b0;
  endtask

  task automatic word(input logic [3:0] s, input logic [1:0] o, input logic a, input logic c);
    bus.user_data       = mkword(base);
    bus.user_sync       = s;
    bus.user_outofrange = o;
    bus.user_data_valid = 1'b0;
    bus.arm             = a;
    bus.ovr_clr         = c;
    base                = base + 8'd8;
    tick();
    idle_inputs();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_data"},      bus.out_data,      64'h0);
    chk({tag, "_out_valid"},     bus.out_valid,     64'h0);
    chk({tag, "_out_sync"},      bus.out_sync,      64'h0);
    chk({tag, "_phase"},         bus.phase,         64'h0);
    chk({tag, "_aligned"},       bus.aligned,       64'h0);
    chk({tag, "_sync_period"},   bus.sync_period,   64'h0);
    chk({tag, "_period_stable"}, bus.period_stable, 64'h0);
    chk({tag, "_ovr_count"},     bus.ovr_count,     64'h0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.user_data = 64'h0;
    idle_inputs();
    base = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    check_zero("reset");

    // Plain stream, p=0: one-word delay
    word(4'b0000, 2'b00, 1'b0, 1'b0);
    chk("w0_no_frame", bus.out_valid, 64'h0);
    word(4'b0000, 2'b00, 1'b0, 1'b0);
    chk("w1_valid", bus.out_valid, 64'h1);
    chk("w1_data",  bus.out_data,  64'h0706050403020100);
    word(4'b0000, 2'b00, 1'b0, 1'b0);
    chk("w2_valid",   bus.out_valid,   64'h1);
    chk("w2_data",    bus.out_data,    64'h0f0e0d0c0b0a0908);
    chk("w2_aligned", bus.aligned,     64'h0);
    chk("w2_phase",   bus.phase,       64'h0);
    chk("w2_period",  bus.sync_period, 64'h0);
    chk("w2_ovr",     bus.ovr_count,   64'h0);
    chk("w2_osync",   bus.out_sync,    64'h0);
    tick();
    chk("idle_valid", bus.out_valid, 64'h0);
    chk("idle_hold",  bus.out_data,  64'h0f0e0d0c0b0a0908);

    // Arm, then sync on phase 2
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk("armed_aligned", bus.aligned, 64'h0);
    base = 8'h10;
    word(4'b0100, 2'b00, 1'b0, 1'b0);
    chk("a_phase",   bus.phase,       64'h2);
    chk("a_aligned", bus.aligned,     64'h1);
    chk("a_data",    bus.out_data,    64'h1716151413121110);
    chk("a_osync",   bus.out_sync,    64'h0);
    chk("a_period",  bus.sync_period, 64'h0);
    word(4'b0000, 2'b00, 1'b0, 1'b0);
    chk("b_valid", bus.out_valid, 64'h1);
    chk("b_data",  bus.out_data,  64'h1b1a191817161514);
    chk("b_osync", bus.out_sync,  64'h1);

    // Five empty cycles inside the stream
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gap_valid", bus.out_valid, 64'h0);
      chk("gap_hold",  bus.out_data,  64'h1b1a191817161514);
    end
    word(4'b0000, 2'b00, 1'b0, 1'b0);
    chk("c_data",  bus.out_data, 64'h232221201f1e1d1c);
    chk("c_osync", bus.out_sync, 64'h0);

    // Sync edges 16 words apart (A was word 0), then 17 apart
    repeat (13) word(4'b0000, 2'b00, 1'b0, 1'b0);
    word(4'b0100, 2'b00, 1'b0, 1'b0);
    chk("e1_period", bus.sync_period,   64'd16);
    chk("e1_stable", bus.period_stable, 64'h0);
    word(4'b0000, 2'b00, 1'b0, 1'b0);
    chk("e1_osync", bus.out_sync, 64'h1);
    repeat (14) word(4'b0000, 2'b00, 1'b0, 1'b0);
    word(4'b0100, 2'b00, 1'b0, 1'b0);
    chk("e2_period", bus.sync_period,   64'd16);
    chk("e2_stable", bus.period_stable, 64'h1);
    repeat (15) word(4'b0000, 2'b00, 1'b0, 1'b0);
    word(4'b0100, 2'b00, 1'b0, 1'b0);
    chk("e3_period", bus.sync_period,   64'd16);
    chk("e3_stable", bus.period_stable, 64'h1);
    repeat (16) word(4'b0000, 2'b00, 1'b0, 1'b0);
    word(4'b0100, 2'b00, 1'b0, 1'b0);
    chk("e4_period", bus.sync_period,   64'd17);
    chk("e4_stable", bus.period_stable, 64'h0);
    chk("e4_phase",  bus.phase,         64'h2);
    chk("e4_ovr",    bus.ovr_count,     64'h0);

    // Overrange saturation, then clear against a coincident overrange word
    repeat (65534) word(4'b0000, 2'b01, 1'b0, 1'b0);
    chk("ovr_fffe", bus.ovr_count, 64'hfffe);
    word(4'b0000, 2'b01, 1'b0, 1'b0);
    chk("ovr_ffff", bus.ovr_count, 64'hffff);
    repeat (2) word(4'b0000, 2'b11, 1'b0, 1'b0);
    chk("ovr_sat", bus.ovr_count, 64'hffff);
    word(4'b0000, 2'b10, 1'b0, 1'b1);
    chk("ovr_clr", bus.ovr_count, 64'h0);

    // Arm coinciding with a sync word: that word is ignored for the phase search
    word(4'b0001, 2'b01, 1'b1, 1'b0);
    chk("rearm_aligned", bus.aligned,       64'h0);
    chk("rearm_ovr",     bus.ovr_count,     64'h1);
    chk("rearm_period",  bus.sync_period,   64'd17);
    chk("rearm_stable",  bus.period_stable, 64'h0);
    bx = base;
    word(4'b1000, 2'b00, 1'b0, 1'b0);
    chk("p3_phase",   bus.phase,   64'h3);
    chk("p3_aligned", bus.aligned, 64'h1);
    word(4'b0000, 2'b00, 1'b0, 1'b0);
    chk("p3_data",  bus.out_data, mkword(bx + 8'd6));
    chk("p3_osync", bus.out_sync, 64'h1);

    // Reset while aligned drops the history word
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("midreset");
    bx = base;
    word(4'b0000, 2'b00, 1'b0, 1'b0);
    chk("post_rst_no_frame", bus.out_valid, 64'h0);
    word(4'b0000, 2'b00, 1'b0, 1'b0);
    chk("post_rst_valid", bus.out_valid, 64'h1);
    chk("post_rst_data",  bus.out_data,  mkword(bx));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
